// File: rtl/cv32e40p_pkg.sv
// Shared cv32e40p definitions used by the ID-stage select monitor.
// Holds monitor states, mask indexing helper and default select channel map.
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        ARMING = 2'd0,
        ARMED  = 2'd1,
        FIRED  = 2'd2
    } mon_state_e;

    localparam int unsigned SEL_CH_ALU_OP_A   = 0;
    localparam int unsigned SEL_CH_ALU_OP_B   = 1;
    localparam int unsigned SEL_CH_ALU_OP_C   = 2;
    localparam int unsigned SEL_CH_BMASK_B    = 3;
    localparam int unsigned SEL_CH_CTRL_TGT   = 4;

    // Bit position of (channel, value) in a flattened per-value illegal bitmap.
    function automatic int unsigned mon_mask_idx(
        input int unsigned ch,
        input int unsigned val,
        input int unsigned sel_w
    );
        return ch * (32'd1 << sel_w) + val;
    endfunction

endpackage

// File: rtl/cv32e40p_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear and increment together leave the counter at one.
module cv32e40p_sat_counter
    import cv32e40p_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= inc_i ? WIDTH'(1) : '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cv32e40p_id_sel_monitor.sv
// Run-time monitor for illegal ID-stage mux-select combinations.
// Optional concurrent checks: define CV32E40P_ID_SEL_MONITOR_ASSERT_EN.
module cv32e40p_id_sel_monitor
    import cv32e40p_pkg::*;
#(
    parameter int N_CH      = 5,
    parameter int SEL_W     = 3,
    parameter int CNT_W     = 8,
    parameter int ARM_DELAY = 4,
    parameter logic [N_CH*(2**SEL_W)-1:0] ILLEGAL_MASK = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    id_valid_i,
    input  logic [31:0]             instr_rdata_i,
    input  logic                    is_compressed_id_i,
    input  logic [N_CH*SEL_W-1:0]   sel_i,
    input  logic                    clr_i,
    output logic                    armed_o,
    output logic                    fired_o,
    output logic                    viol_pulse_o,
    output logic [(N_CH>1 ? $clog2(N_CH) : 1)-1:0] first_ch_o,
    output logic [SEL_W-1:0]        first_sel_o,
    output logic [31:0]             first_instr_o,
    output logic                    first_cmp_o,
    output logic [N_CH*CNT_W-1:0]   hit_cnt_o
);

    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int NV       = 2 ** SEL_W;
    localparam int DLY_W    = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;
    localparam int DLY_LAST = (ARM_DELAY > 0) ? ARM_DELAY - 1 : 0;
    localparam mon_state_e RST_STATE = (ARM_DELAY == 0) ? ARMED : ARMING;

    mon_state_e       state_q;
    logic [DLY_W-1:0] dly_q;
    logic [SEL_W-1:0] sel_ch [N_CH];
    logic [N_CH-1:0]  illegal;
    logic             viol;
    logic             cap_en;
    logic [CH_W-1:0]  first_ch_d;
    logic [SEL_W-1:0] first_sel_d;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [NV-1:0] ch_mask;

        assign ch_mask    = ILLEGAL_MASK[mon_mask_idx(c, 0, SEL_W) +: NV];
        assign sel_ch[c]  = sel_i[c*SEL_W +: SEL_W];
        assign illegal[c] = ch_mask[sel_ch[c]];

        cv32e40p_sat_counter #(
            .WIDTH (CNT_W)
        ) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc_i (viol && illegal[c]),
            .clr_i (clr_i),
            .cnt_o (hit_cnt_o[c*CNT_W +: CNT_W])
        );

`ifdef CV32E40P_ID_SEL_MONITOR_ASSERT_EN
        a_sel_legal: assert property (
            @(posedge clk_i) disable iff (rst_i)
            (id_valid_i && armed_o) |-> !illegal[c]
        ) else $error("illegal select: ch %0d sel %0d instr %08h",
                      c, sel_ch[c], instr_rdata_i);
`endif
    end

    assign viol   = id_valid_i && (|illegal) && (state_q != ARMING);
    // A clear in FIRED re-opens the capture for a same-cycle violation.
    assign cap_en = viol && ((state_q != FIRED) || clr_i);

    always_comb begin
        first_ch_d  = '0;
        first_sel_d = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (illegal[c]) begin
                first_ch_d  = CH_W'(c);
                first_sel_d = sel_ch[c];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= RST_STATE;
            dly_q         <= '0;
            armed_o       <= 1'b0;
            fired_o       <= 1'b0;
            viol_pulse_o  <= 1'b0;
            first_ch_o    <= '0;
            first_sel_o   <= '0;
            first_instr_o <= '0;
            first_cmp_o   <= 1'b0;
        end else begin
            viol_pulse_o <= viol;

            if (cap_en) begin
                first_ch_o    <= first_ch_d;
                first_sel_o   <= first_sel_d;
                first_instr_o <= instr_rdata_i;
                first_cmp_o   <= is_compressed_id_i;
            end else if (clr_i) begin
                first_ch_o    <= '0;
                first_sel_o   <= '0;
                first_instr_o <= '0;
                first_cmp_o   <= 1'b0;
            end

            unique case (state_q)
                ARMING: begin
                    if (dly_q == DLY_W'(DLY_LAST)) begin
                        state_q <= ARMED;
                        armed_o <= 1'b1;
                    end else begin
                        dly_q <= dly_q + DLY_W'(1);
                    end
                end
                ARMED: begin
                    armed_o <= 1'b1;
                    if (viol) begin
                        state_q <= FIRED;
                        fired_o <= 1'b1;
                    end
                end
                FIRED: begin
                    armed_o <= 1'b1;
                    if (clr_i && !viol) begin
                        state_q <= ARMED;
                        fired_o <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ARMING;
                    armed_o <= 1'b0;
                    fired_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40p_id_sel_monitor.sv
// Scoreboard bench for cv32e40p_id_sel_monitor.
// Expected captures are queued at issue and checked on each violation pulse.
module tb_cv32e40p_id_sel_monitor;

    localparam int N_CH      = 5;
    localparam int SEL_W     = 3;
    localparam int CNT_W     = 4;
    localparam int ARM_DELAY = 4;
    localparam logic [39:0] MASK = (40'd1 << 19) | (40'd1 << 32);

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] instr;
    logic        cmp;
    logic [14:0] sel;
    logic        clr;
    logic        armed;
    logic        fired;
    logic        viol_pulse;
    logic [2:0]  first_ch;
    logic [2:0]  first_sel;
    logic [31:0] first_instr;
    logic        first_cmp;
    logic [19:0] hit_cnt;

    typedef struct packed {
        logic [2:0]  ch;
        logic [2:0]  sel;
        logic [31:0] instr;
        logic        cmp;
        logic [3:0]  c2;
        logic [3:0]  c4;
        logic        fired;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    cv32e40p_id_sel_monitor #(
        .N_CH         (N_CH),
        .SEL_W        (SEL_W),
        .CNT_W        (CNT_W),
        .ARM_DELAY    (ARM_DELAY),
        .ILLEGAL_MASK (MASK)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .id_valid_i         (id_valid),
        .instr_rdata_i      (instr),
        .is_compressed_id_i (cmp),
        .sel_i              (sel),
        .clr_i              (clr),
        .armed_o            (armed),
        .fired_o            (fired),
        .viol_pulse_o       (viol_pulse),
        .first_ch_o         (first_ch),
        .first_sel_o        (first_sel),
        .first_instr_o      (first_instr),
        .first_cmp_o        (first_cmp),
        .hit_cnt_o          (hit_cnt)
    );

    function automatic logic [14:0] mk_sel(input logic [2:0] s2,
                                           input logic [2:0] s4);
        return {s4, 3'd0, s2, 3'd0, 3'd0};
    endfunction

    function automatic logic [3:0] cnt(input int c);
        return hit_cnt[c*CNT_W +: CNT_W];
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] s2,
                         input logic [2:0] s4, input logic [31:0] ins,
                         input logic c, input logic cl);
        id_valid = v;
        sel      = mk_sel(s2, s4);
        instr    = ins;
        cmp      = c;
        clr      = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 3'd1, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [2:0] ch, input logic [2:0] s,
                        input logic [31:0] ins, input logic c,
                        input logic [3:0] c2, input logic [3:0] c4);
        exp_t e;
        e = '{ch: ch, sel: s, instr: ins, cmp: c, c2: c2, c4: c4, fired: 1'b1};
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && viol_pulse) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got 1 required 0");
            end else begin
                e = sbq.pop_front();
                check("sb_first_ch", 64'(first_ch), 64'(e.ch));
                check("sb_first_sel", 64'(first_sel), 64'(e.sel));
                check("sb_first_instr", 64'(first_instr), 64'(e.instr));
                check("sb_first_cmp", 64'(first_cmp), 64'(e.cmp));
                check("sb_cnt_ch2", 64'(cnt(2)), 64'(e.c2));
                check("sb_cnt_ch4", 64'(cnt(4)), 64'(e.c4));
                check("sb_fired", 64'(fired), 64'(e.fired));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b0;
        id_valid = 1'b0;
        sel      = mk_sel(3'd0, 3'd1);
        instr    = '0;
        cmp      = 1'b0;
        clr      = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("reset_outputs",
              64'({armed, fired, viol_pulse, first_ch, first_sel,
                   first_instr, first_cmp, hit_cnt}), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Violations during the arming window are ignored.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd3, 3'd1, 32'h0062_8533, 1'b0, 1'b0);
            check("arming_armed", 64'(armed), 64'(0));
            check("arming_cnt_ch2", 64'(cnt(2)), 64'(0));
        end
        idle();
        check("armed_rise", 64'(armed), 64'(1));
        check("armed_not_fired", 64'(fired), 64'(0));

        // First capture.
        push(3'd2, 3'd3, 32'h0062_8533, 1'b0, 4'd1, 4'd0);
        drive(1'b1, 3'd3, 3'd1, 32'h0062_8533, 1'b0, 1'b0);
        idle();
        check("pulse_one_cycle", 64'(viol_pulse), 64'(0));

        // Clear from FIRED returns to ARMED with empty state.
        drive(1'b0, 3'd0, 3'd1, 32'h0, 1'b0, 1'b1);
        check("clr_fired", 64'(fired), 64'(0));
        check("clr_armed", 64'(armed), 64'(1));
        check("clr_counts", 64'(hit_cnt), 64'(0));
        check("clr_capture", 64'(first_instr), 64'(0));

        // Two channels together, then ch4 alone: capture stays on ch2.
        push(3'd2, 3'd3, 32'h0000_4501, 1'b1, 4'd1, 4'd1);
        drive(1'b1, 3'd3, 3'd0, 32'h0000_4501, 1'b1, 1'b0);
        push(3'd2, 3'd3, 32'h0000_4501, 1'b1, 4'd1, 4'd2);
        drive(1'b1, 3'd0, 3'd0, 32'h00a5_0533, 1'b0, 1'b0);

        // Invalid cycles with illegal selects are inert.
        drive(1'b0, 3'd3, 3'd0, 32'hdead_beef, 1'b0, 1'b0);
        check("invalid_cnt_ch4", 64'(cnt(4)), 64'(2));

        // Clear and violation in the same cycle.
        push(3'd4, 3'd0, 32'h0040_00ef, 1'b0, 4'd0, 4'd1);
        drive(1'b1, 3'd0, 3'd0, 32'h0040_00ef, 1'b0, 1'b1);
        idle();
        check("clrviol_fired", 64'(fired), 64'(1));

        // Saturation of the ch2 counter.
        drive(1'b0, 3'd0, 3'd1, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            push(3'd2, 3'd3, 32'h1234_5678, 1'b0,
                 (i < 15) ? 4'(i + 1) : 4'd15, 4'd0);
            drive(1'b1, 3'd3, 3'd1, 32'h1234_5678, 1'b0, 1'b0);
        end
        idle();
        check("sat_hold", 64'(cnt(2)), 64'(15));

        // Asynchronous reset between clock edges while FIRED.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs",
              64'({armed, fired, viol_pulse, first_ch, first_sel,
                   first_instr, first_cmp, hit_cnt}), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            check("rearm_armed_low", 64'(armed), 64'(0));
        end
        idle();
        check("rearm_armed_high", 64'(armed), 64'(1));

        idle();
        check("scoreboard_drained", 64'(sbq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
